// File: rtl/adc_trigger.sv
// adc_trigger: level/slope/hysteresis trigger detector with post-trigger holdoff.
// Define ADC_TRIG_AUTO_EN to build the auto-trigger timeout (acnt / auto_timeout).
module adc_trigger #(
  parameter int DW     = 8,
  parameter int HOLD_W = 16,
  parameter int AUTO_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_en,
  input  logic [2*DW-1:0]   adc_data,
  input  logic [31:0]       cfg,
  input  logic [HOLD_W-1:0] holdoff,
  input  logic [AUTO_W-1:0] auto_timeout,
  output logic              trig_req,
  output logic              trig_auto,
  output logic              armed
);

  typedef enum logic [1:0] {IDLE, HOLDOFF, ARM, READY} state_e;

  logic              enable, chan_b, slope_fall;
  logic [DW-1:0]     level, hyst, lo, hi;
  logic [DW:0]       hi_sum;
  logic [DW-1:0]     s_d, s_q;
  logic              v_d, v_q;
  state_e            state_d, state_q;
  logic [HOLD_W-1:0] hcnt_d, hcnt_q;
  logic              trig_req_d, trig_req_q;
  logic              trig_auto_d, trig_auto_q;
  logic              armed_d, armed_q;
  logic              pre_hit, cross_hit, real_fire, auto_hit;

  assign level      = DW'(cfg[7:0]);
  assign hyst       = DW'(cfg[11:8]);
  assign chan_b     = cfg[12];
  assign slope_fall = cfg[13];
  assign enable     = cfg[14];

  // Saturating thresholds: lo clamps at 0, hi clamps at full scale.
  assign lo     = (level > hyst) ? level - hyst : '0;
  assign hi_sum = {1'b0, level} + {1'b0, hyst};
  assign hi     = hi_sum[DW] ? '1 : hi_sum[DW-1:0];

  assign s_d = chan_b ? adc_data[DW-1:0] : adc_data[2*DW-1:DW];
  assign v_d = sample_en;

  assign pre_hit   = slope_fall ? (s_q > hi) : (s_q < lo);
  assign cross_hit = slope_fall ? (s_q <= level) : (s_q >= level);
  assign real_fire = v_q && (state_q == READY) && cross_hit;

`ifdef ADC_TRIG_AUTO_EN
  logic [AUTO_W-1:0] acnt_d, acnt_q;
  logic [AUTO_W:0]   acnt_inc;

  // A timeout of 0 can never match acnt + 1, which disables the feature.
  assign acnt_inc = {1'b0, acnt_q} + (AUTO_W+1)'(1);
  assign auto_hit = v_q && (acnt_inc == {1'b0, auto_timeout});

  logic unused_ok;
  assign unused_ok = ^cfg[31:15];
`else
  assign auto_hit = 1'b0;

  logic unused_ok;
  assign unused_ok = ^{cfg[31:15], auto_timeout};
`endif

  // NOTE: every _d gets its hold value first so no path through this block infers a latch.
  always_comb begin
    state_d     = state_q;
    hcnt_d      = hcnt_q;
    trig_req_d  = 1'b0;
    trig_auto_d = 1'b0;
`ifdef ADC_TRIG_AUTO_EN
    acnt_d      = acnt_q;
`endif
    if (!enable) begin
      state_d = IDLE;
      hcnt_d  = '0;
`ifdef ADC_TRIG_AUTO_EN
      acnt_d  = '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          state_d = HOLDOFF;
          hcnt_d  = holdoff;
        end
        HOLDOFF: begin
          if (hcnt_q == '0) begin
            state_d = ARM;
`ifdef ADC_TRIG_AUTO_EN
            acnt_d  = '0;
`endif
          end else if (v_q) begin
            hcnt_d = hcnt_q - HOLD_W'(1);
          end
        end
        ARM, READY: begin
          if (real_fire || auto_hit) begin
            // A real crossing on the timeout sample wins, so it is not flagged auto.
            trig_req_d  = 1'b1;
            trig_auto_d = !real_fire;
            state_d     = HOLDOFF;
            hcnt_d      = holdoff;
          end else if (v_q) begin
            if (state_q == ARM && pre_hit) state_d = READY;
`ifdef ADC_TRIG_AUTO_EN
            if (!acnt_inc[AUTO_W]) acnt_d = acnt_inc[AUTO_W-1:0];
`endif
          end
        end
        default: state_d = IDLE;
      endcase
    end
    armed_d = (state_d == ARM) || (state_d == READY);
  end

  // NOTE: state is updated with <= so every flop samples the pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      hcnt_q      <= '0;
      s_q         <= '0;
      v_q         <= 1'b0;
      trig_req_q  <= 1'b0;
      trig_auto_q <= 1'b0;
      armed_q     <= 1'b0;
`ifdef ADC_TRIG_AUTO_EN
      acnt_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      hcnt_q      <= hcnt_d;
      s_q         <= s_d;
      v_q         <= v_d;
      trig_req_q  <= trig_req_d;
      trig_auto_q <= trig_auto_d;
      armed_q     <= armed_d;
`ifdef ADC_TRIG_AUTO_EN
      acnt_q      <= acnt_d;
`endif
    end
  end

  assign trig_req  = trig_req_q;
  assign trig_auto = trig_auto_q;
  assign armed     = armed_q;

endmodule

// File: tb/tb_adc_trigger.sv
// Scoreboard bench for adc_trigger: a cycle reference model pushes expected outputs
// per driven cycle; directed scenarios add pulse count / spacing / latency checks.
`timescale 1ns/1ps
module tb_adc_trigger;
  localparam int DW = 8, HOLD_W = 16, AUTO_W = 24;

  logic        clk = 1'b0;
  logic        rst;
  logic        sample_en;
  logic [15:0] adc_data;
  logic [31:0] cfg;
  logic [15:0] holdoff;
  logic [23:0] auto_timeout;
  logic        trig_req, trig_auto, armed;

  adc_trigger #(.DW(DW), .HOLD_W(HOLD_W), .AUTO_W(AUTO_W)) dut (
    .clk(clk), .rst(rst), .sample_en(sample_en), .adc_data(adc_data), .cfg(cfg),
    .holdoff(holdoff), .auto_timeout(auto_timeout),
    .trig_req(trig_req), .trig_auto(trig_auto), .armed(armed)
  );

  always #5 clk = ~clk;

`ifdef ADC_TRIG_AUTO_EN
  localparam bit AUTO_ON = 1'b1;
`else
  localparam bit AUTO_ON = 1'b0;
`endif

  typedef struct packed {logic trig; logic auto_f; logic e_armed;} exp_t;
  exp_t sb_q[$];

  int n_vec = 0, n_err = 0;
  int cyc = 0;
  int pulses, first_pulse_cyc, first_auto, trig_sample, prev_pulse, min_gap, armed_cyc;
  int cur_sel = 0, prev_sel = 0;
  int en_start;

  // Reference model state (IDLE=0, HOLDOFF=1, ARM=2, READY=3)
  int     m_state, m_hcnt, m_s, m_v;
  longint m_acnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mk_cfg(input int lvl, input int hy, input bit ch,
                                         input bit fall, input bit en);
    logic [16:0] rsv;
    rsv = 17'($urandom);
    return {rsv, en, fall, ch, 4'(hy), 8'(lvl)};
  endfunction

  task automatic model_reset();
    m_state = 0; m_hcnt = 0; m_acnt = 0; m_s = 0; m_v = 0;
  endtask

  task automatic model_step(output exp_t e);
    int lvl, hy, lo_t, hi_t;
    bit en, rising, fire, pre, ahit;
    en     = cfg[14];
    rising = !cfg[13];
    lvl    = int'(cfg[7:0]);
    hy     = int'(cfg[11:8]);
    lo_t   = (lvl - hy < 0) ? 0 : lvl - hy;
    hi_t   = (lvl + hy > 255) ? 255 : lvl + hy;
    e      = '0;
    if (!en) begin
      m_state = 0; m_hcnt = 0; m_acnt = 0;
    end else if (m_state == 0) begin
      m_state = 1; m_hcnt = int'(holdoff);
    end else if (m_state == 1) begin
      if (m_hcnt == 0) begin m_state = 2; m_acnt = 0; end
      else if (m_v != 0) m_hcnt--;
    end else if (m_v != 0) begin
      fire = (m_state == 3) && (rising ? (m_s >= lvl) : (m_s <= lvl));
      pre  = (m_state == 2) && (rising ? (m_s < lo_t) : (m_s > hi_t));
      ahit = AUTO_ON && (auto_timeout != 0) && (m_acnt + 1 == longint'(auto_timeout));
      if (fire || ahit) begin
        e.trig = 1'b1; e.auto_f = !fire; m_state = 1; m_hcnt = int'(holdoff);
      end else begin
        if (pre) m_state = 3;
        if (m_acnt < 64'd16777215) m_acnt++;
      end
    end
    e.e_armed = (m_state >= 2);
    m_s = cfg[12] ? int'(adc_data[7:0]) : int'(adc_data[15:8]);
    m_v = sample_en;
  endtask

  task automatic mark();
    pulses = 0; first_pulse_cyc = -1; first_auto = -1; trig_sample = -1;
    prev_pulse = -1; min_gap = 1000000; armed_cyc = -1;
  endtask

  // Drive one cycle, push the model's expectation, pop and compare after the edge.
  task automatic cycle(input logic se, input logic [15:0] d);
    exp_t e, exp_e;
    sample_en = se;
    adc_data  = d;
    prev_sel  = cur_sel;
    cur_sel   = cfg[12] ? int'(d[7:0]) : int'(d[15:8]);
    model_step(e);
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      exp_e = sb_q.pop_front();
      check("trig_req", trig_req, exp_e.trig);
      check("trig_auto", trig_auto, exp_e.auto_f);
      check("armed", armed, exp_e.e_armed);
    end
    if (armed && armed_cyc < 0) armed_cyc = cyc;
    if (trig_req) begin
      pulses++;
      trig_sample = prev_sel;
      if (first_pulse_cyc < 0) begin first_pulse_cyc = cyc; first_auto = trig_auto; end
      if (prev_pulse >= 0 && cyc - prev_pulse < min_gap) min_gap = cyc - prev_pulse;
      prev_pulse = cyc;
    end
  endtask

  task automatic idle_off();
    cfg[14] = 1'b0;
    repeat (2) cycle(1'b0, 16'h0000);
  endtask

  task automatic wait_armed(input logic [15:0] d, input string tag);
    for (int i = 0; i < 50 && !armed; i++) cycle(1'b1, d);
    check(tag, armed, 1'b1);
  endtask

  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    check({tag, "_req"}, trig_req, 1'b0);
    check({tag, "_auto"}, trig_auto, 1'b0);
    check({tag, "_armed"}, armed, 1'b0);
    model_reset();
    sb_q.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cur_sel = 0;
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; sample_en = 1'b0; adc_data = '0; cfg = '0; holdoff = '0; auto_timeout = '0;
    model_reset();
    mark();
    repeat (2) @(negedge clk);
    check("rst_req", trig_req, 1'b0);
    check("rst_auto", trig_auto, 1'b0);
    check("rst_armed", armed, 1'b0);
    rst = 1'b0;

    // Rising ramp on channel A through level 0x80
    cfg = mk_cfg(8'h80, 4, 1'b0, 1'b0, 1'b1);
    mark();
    repeat (3) cycle(1'b0, 16'h0000);
    for (int v = 8'h70; v <= 8'h90; v++) cycle(1'b1, {v[7:0], ~v[7:0]});
    repeat (3) cycle(1'b0, 16'h0000);
    check("ramp_pulses", pulses, 1);
    check("ramp_sample", trig_sample, 8'h80);
    check("ramp_auto", first_auto, 0);

    // Falling on channel B with dither around the level; A toggles to prove channel select
    idle_off();
    cfg = mk_cfg(8'h40, 2, 1'b1, 1'b1, 1'b1);
    mark();
    repeat (3) cycle(1'b0, 16'h0000);
    cycle(1'b1, 16'h0050); cycle(1'b1, 16'hFF45); cycle(1'b1, 16'h0041); cycle(1'b1, 16'hFF3F);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 16'h0041);
      cycle(1'b1, 16'hFF3F);
    end
    check("dither_pulses", pulses, 1);
    cycle(1'b1, 16'h0043); cycle(1'b1, 16'hFF40);
    repeat (2) cycle(1'b0, 16'h0000);
    check("rearm_pulses", pulses, 2);
    check("rearm_sample", trig_sample, 8'h40);

    // Holdoff 10 against a square wave that crosses every 3 samples
    idle_off();
    cfg = mk_cfg(8'h80, 4, 1'b0, 1'b0, 1'b1);
    holdoff = 16'd10;
    mark();
    for (int i = 0; i < 80; i++) cycle(1'b1, (((i / 3) % 2) != 0) ? 16'hF000 : 16'h1000);
    check("holdoff_pulses", (pulses >= 3), 1'b1);
    check("holdoff_gap", (min_gap >= 11), 1'b1);

    // Saturated thresholds can never be pre-conditioned
    idle_off();
    holdoff = '0;
    cfg = mk_cfg(8'h02, 8, 1'b0, 1'b0, 1'b1);
    mark();
    for (int i = 0; i < 60; i++) cycle(1'b1, {8'(i * 5), 8'h00});
    check("lo_sat_pulses", pulses, 0);
    idle_off();
    cfg = mk_cfg(8'hFD, 8, 1'b0, 1'b1, 1'b1);
    mark();
    for (int i = 0; i < 60; i++) cycle(1'b1, {8'(255 - i * 4), 8'hFF});
    check("hi_sat_pulses", pulses, 0);

`ifdef ADC_TRIG_AUTO_EN
    // Forced trigger on the 5th sample after arming; a real crossing on it wins
    idle_off();
    cfg = mk_cfg(8'h80, 4, 1'b0, 1'b0, 1'b1);
    auto_timeout = 24'd5;
    mark();
    wait_armed(16'h9000, "auto_arm_timeout");
    repeat (8) cycle(1'b1, 16'h9000);
    check("auto_latency", first_pulse_cyc - armed_cyc, 5);
    check("auto_flag", first_auto, 1);
    idle_off();
    cfg = mk_cfg(8'h80, 4, 1'b0, 1'b0, 1'b1);
    mark();
    wait_armed(16'h7000, "auto_arm2_timeout");
    for (int k = 1; k <= 8; k++) cycle(1'b1, (k == 4) ? 16'h8000 : 16'h7000);
    check("race_latency", first_pulse_cyc - armed_cyc, 5);
    check("race_flag", first_auto, 0);
`else
    // Timeout input is ignored when the auto-trigger is not built
    idle_off();
    cfg = mk_cfg(8'h80, 4, 1'b0, 1'b0, 1'b1);
    auto_timeout = 24'd5;
    mark();
    repeat (20) cycle(1'b1, 16'h9000);
    check("no_auto_pulses", pulses, 0);
`endif

    // Enable drop while READY, then full holdoff reload on re-enable
    idle_off();
    auto_timeout = '0;
    cfg = mk_cfg(8'h80, 4, 1'b0, 1'b0, 1'b1);
    mark();
    wait_armed(16'h7000, "ready_arm_timeout");
    cycle(1'b1, 16'h9000);
    cfg[14] = 1'b0;
    cycle(1'b1, 16'h9000);
    check("drop_armed", armed, 1'b0);
    repeat (2) cycle(1'b1, 16'h9000);
    check("drop_pulses", pulses, 0);
    holdoff = 16'd10;
    cfg[14] = 1'b1;
    en_start = cyc + 1;
    mark();
    wait_armed(16'h9000, "reen_arm_timeout");
    check("reen_reload", armed_cyc - en_start, 11);

    // Asynchronous reset while armed, then while in HOLDOFF
    async_reset("rst_arm");
    repeat (4) cycle(1'b1, 16'h9000);
    async_reset("rst_hold");
    en_start = cyc + 1;
    mark();
    wait_armed(16'h9000, "rst_arm_timeout");
    check("rst_reload", armed_cyc - en_start, 11);

    // Random soak against the reference model
    for (int blk = 0; blk < 10; blk++) begin
      cfg = mk_cfg(int'($urandom_range(0, 255)), int'($urandom_range(0, 15)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 9) != 0));
      holdoff      = 16'($urandom_range(0, 4));
      auto_timeout = 24'($urandom_range(0, 6));
      for (int i = 0; i < 40; i++) cycle(($urandom_range(0, 3) != 0), 16'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
